// File: rtl/schedule_scoreboard_pkg.sv
// Shared decode constants and helpers for the schedule stage scoreboard.
// Opcode/funct7 values are reused by decode and execute.
package schedule_scoreboard_pkg;

  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_OP         = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 4;

  // One-hot vector for a register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] idx);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Loads and M-extension mul/div complete after an unknown number of cycles.
  function automatic logic is_long_latency(input logic [6:0] opcode,
                                           input logic [6:0] funct7);
    is_long_latency = (opcode == OP_LOAD) ||
                      ((opcode == OP_OP) && (funct7 == FUNCT7_MULDIV));
  endfunction

endpackage

// File: rtl/sb_regmask.sv
// 32-bit busy-register mask: clear then set, set wins on the same bit,
// and x0 can never become busy.
module sb_regmask
  import schedule_scoreboard_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR_EN,
  input  logic [4:0]          CLR_IDX,
  input  logic                SET_EN,
  input  logic [4:0]          SET_IDX,
  output logic [NUM_REGS-1:0] MASK
);

  logic [NUM_REGS-1:0] mask_r;
  logic [NUM_REGS-1:0] clr_vec_s;
  logic [NUM_REGS-1:0] set_vec_s;
  logic [NUM_REGS-1:0] mask_next_s;

  // Next mask: drop the written-back register, then add the newly issued one.
  always_comb begin
    clr_vec_s   = {NUM_REGS{1'b0}};
    set_vec_s   = {NUM_REGS{1'b0}};
    mask_next_s = mask_r;
    if (CLR_EN) begin
      clr_vec_s = reg_onehot(CLR_IDX);
    end else begin
      clr_vec_s = {NUM_REGS{1'b0}};
    end
    if (SET_EN) begin
      set_vec_s = reg_onehot(SET_IDX);
    end else begin
      set_vec_s = {NUM_REGS{1'b0}};
    end
    mask_next_s    = (mask_r & ~clr_vec_s) | set_vec_s;
    mask_next_s[0] = 1'b0;
  end

  // Mask register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_r <= {NUM_REGS{1'b0}};
    end else begin
      mask_r <= mask_next_s;
    end
  end

  assign MASK = mask_r;

endmodule

// File: rtl/schedule_scoreboard.sv
// Schedule stage issue controller: holds back candidates that read or write a
// register with an outstanding long-latency write, and tracks how many such
// writes are in flight.
module schedule_scoreboard
  import schedule_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic        CHECK_VALID,
  input  logic [6:0]  CHECK_OPCODE,
  input  logic [6:0]  CHECK_FUNCT7,
  input  logic [4:0]  CHECK_RS1,
  input  logic [4:0]  CHECK_RS2,
  input  logic [4:0]  CHECK_RD,
  input  logic        CHECK_RS1_USE,
  input  logic        CHECK_RS2_USE,
  input  logic        CHECK_RD_WE,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  output logic        SCHEDULE_VALID,
  output logic        SCHEDULE_STALL,
  output logic [31:0] PENDING_MASK,
  output logic [3:0]  PENDING_CNT
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0] mask_s;
  logic [NUM_REGS-1:0] eff_busy_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_next_s;
  logic                sched_valid_r;
  logic                long_s;
  logic                hazard_s;
  logic                full_s;
  logic                issue_s;
  logic                stall_s;
  logic                wb_clr_s;
  logic                set_en_s;
  logic                inc_s;
  logic                dec_s;

  assign long_s = is_long_latency(CHECK_OPCODE, CHECK_FUNCT7);

  // Hazard/issue decision; a same-cycle writeback already resolves its register.
  always_comb begin
    eff_busy_s = mask_s;
    if (WB_VALID) begin
      eff_busy_s = mask_s & ~reg_onehot(WB_RD);
    end else begin
      eff_busy_s = mask_s;
    end
    hazard_s = (CHECK_RS1_USE & eff_busy_s[CHECK_RS1]) |
               (CHECK_RS2_USE & eff_busy_s[CHECK_RS2]) |
               (CHECK_RD_WE   & eff_busy_s[CHECK_RD]);
    full_s   = long_s & (cnt_r == MAX_CNT) & ~WB_VALID;
    issue_s  = CHECK_VALID & ~hazard_s & ~full_s & ~MEM_WAIT & ~FLUSH & ~RST;
    stall_s  = CHECK_VALID & ~issue_s & ~FLUSH & ~RST;
  end

  assign wb_clr_s = WB_VALID & (WB_RD != 5'd0);
  assign set_en_s = issue_s & long_s & CHECK_RD_WE;

  sb_regmask u_regmask (
    .CLK     (CLK),
    .RST     (RST),
    .CLR_EN  (wb_clr_s),
    .CLR_IDX (WB_RD),
    .SET_EN  (set_en_s),
    .SET_IDX (CHECK_RD),
    .MASK    (mask_s)
  );

  // Outstanding-write count: issue and writeback cancel; never below zero.
  always_comb begin
    inc_s      = set_en_s & (CHECK_RD != 5'd0);
    dec_s      = wb_clr_s & (cnt_r != {CNT_W{1'b0}});
    cnt_next_s = cnt_r;
    if (inc_s && !dec_s && (cnt_r != CNT_TOP)) begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (dec_s && !inc_s) begin
      cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count and issued-slot registers; flush suppresses issue so the slot empties.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r         <= {CNT_W{1'b0}};
      sched_valid_r <= 1'b0;
    end else begin
      cnt_r         <= cnt_next_s;
      sched_valid_r <= issue_s;
    end
  end

  assign SCHEDULE_VALID = sched_valid_r;
  assign SCHEDULE_STALL = stall_s;
  assign PENDING_MASK   = mask_s;
  assign PENDING_CNT    = cnt_r;

endmodule

// File: tb/tb_schedule_scoreboard.sv
// Directed bench for schedule_scoreboard: expected registered results are
// queued when a cycle is driven and compared after the clock edge.
module tb_schedule_scoreboard;

  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, MEM_WAIT, CHECK_VALID;
  logic [6:0]  CHECK_OPCODE, CHECK_FUNCT7;
  logic [4:0]  CHECK_RS1, CHECK_RS2, CHECK_RD;
  logic        CHECK_RS1_USE, CHECK_RS2_USE, CHECK_RD_WE;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        SCHEDULE_VALID, SCHEDULE_STALL;
  logic [31:0] PENDING_MASK;
  logic [3:0]  PENDING_CNT;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  schedule_scoreboard #(.MAX_PENDING(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FLUSH          (FLUSH),
    .MEM_WAIT       (MEM_WAIT),
    .CHECK_VALID    (CHECK_VALID),
    .CHECK_OPCODE   (CHECK_OPCODE),
    .CHECK_FUNCT7   (CHECK_FUNCT7),
    .CHECK_RS1      (CHECK_RS1),
    .CHECK_RS2      (CHECK_RS2),
    .CHECK_RD       (CHECK_RD),
    .CHECK_RS1_USE  (CHECK_RS1_USE),
    .CHECK_RS2_USE  (CHECK_RS2_USE),
    .CHECK_RD_WE    (CHECK_RD_WE),
    .WB_VALID       (WB_VALID),
    .WB_RD          (WB_RD),
    .SCHEDULE_VALID (SCHEDULE_VALID),
    .SCHEDULE_STALL (SCHEDULE_STALL),
    .PENDING_MASK   (PENDING_MASK),
    .PENDING_CNT    (PENDING_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RST = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0; CHECK_VALID = 1'b0;
    CHECK_OPCODE = 7'd0; CHECK_FUNCT7 = 7'd0;
    CHECK_RS1 = 5'd0; CHECK_RS2 = 5'd0; CHECK_RD = 5'd0;
    CHECK_RS1_USE = 1'b0; CHECK_RS2_USE = 1'b0; CHECK_RD_WE = 1'b0;
    WB_VALID = 1'b0; WB_RD = 5'd0;
  endtask

  task automatic cand(input logic [6:0] opc, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    CHECK_VALID = 1'b1; CHECK_OPCODE = opc; CHECK_FUNCT7 = f7;
    CHECK_RD = rd; CHECK_RD_WE = 1'b1;
    CHECK_RS1 = rs1; CHECK_RS1_USE = u1; CHECK_RS2 = rs2; CHECK_RS2_USE = u2;
  endtask

  task automatic wb(input logic [4:0] rd);
    WB_VALID = 1'b1; WB_RD = rd;
  endtask

  // One clock: combinational stall checked before the edge, registered state after.
  task automatic cycle(input string name, input logic stall, input logic sv,
                       input logic [31:0] mask, input logic [3:0] cnt);
    exp_t e;
    e.tag = {name, ".valid"}; e.exp = {31'd0, sv};   exp_q.push_back(e);
    e.tag = {name, ".mask"};  e.exp = mask;          exp_q.push_back(e);
    e.tag = {name, ".cnt"};   e.exp = {28'd0, cnt};  exp_q.push_back(e);
    #1;
    check_eq({name, ".stall"}, {31'd0, SCHEDULE_STALL}, {31'd0, stall});
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (exp_q.size() == 0) begin
        check_eq({name, ".queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        case (k)
          0:       check_eq(e.tag, {31'd0, SCHEDULE_VALID}, e.exp);
          1:       check_eq(e.tag, PENDING_MASK, e.exp);
          default: check_eq(e.tag, {28'd0, PENDING_CNT}, e.exp);
        endcase
      end
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    @(negedge CLK);
    // Reset
    RST = 1'b1;
    cycle("reset", 1'b0, 1'b0, 32'h0, 4'd0);
    // Independent ALU op ADDI x5, x1
    cand(OPC_IMM, 7'd0, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0);
    cycle("addi", 1'b0, 1'b1, 32'h0, 4'd0);
    // LOAD to x0 never marks busy
    cand(OPC_LOAD, 7'd0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0);
    cycle("load_x0", 1'b0, 1'b1, 32'h0, 4'd0);
    // LOAD x3 then dependent ADD x4,x3,x1
    cand(OPC_LOAD, 7'd0, 5'd3, 5'd2, 1'b1, 5'd0, 1'b0);
    cycle("load_x3", 1'b0, 1'b1, 32'h8, 4'd1);
    cand(OPC_OP, 7'd0, 5'd4, 5'd3, 1'b1, 5'd1, 1'b1);
    cycle("add_raw", 1'b1, 1'b0, 32'h8, 4'd1);
    cand(OPC_OP, 7'd0, 5'd4, 5'd3, 1'b1, 5'd1, 1'b1);
    wb(5'd3);
    cycle("add_wb", 1'b0, 1'b1, 32'h0, 4'd0);
    // Fill to MAX_PENDING with MUL x1..x4
    cand(OPC_OP, 7'd1, 5'd1, 5'd10, 1'b1, 5'd11, 1'b1);
    cycle("mul_x1", 1'b0, 1'b1, 32'h02, 4'd1);
    cand(OPC_OP, 7'd1, 5'd2, 5'd10, 1'b1, 5'd11, 1'b1);
    cycle("mul_x2", 1'b0, 1'b1, 32'h06, 4'd2);
    cand(OPC_OP, 7'd1, 5'd3, 5'd10, 1'b1, 5'd11, 1'b1);
    cycle("mul_x3", 1'b0, 1'b1, 32'h0E, 4'd3);
    cand(OPC_OP, 7'd1, 5'd4, 5'd10, 1'b1, 5'd11, 1'b1);
    cycle("mul_x4", 1'b0, 1'b1, 32'h1E, 4'd4);
    cand(OPC_OP, 7'd1, 5'd6, 5'd10, 1'b1, 5'd11, 1'b1);
    cycle("mul_full", 1'b1, 1'b0, 32'h1E, 4'd4);
    cand(OPC_OP, 7'd1, 5'd6, 5'd10, 1'b1, 5'd11, 1'b1);
    wb(5'd2);
    cycle("mul_full_wb", 1'b0, 1'b1, 32'h5A, 4'd4);
    // Drain
    wb(5'd1); cycle("drain_x1", 1'b0, 1'b0, 32'h58, 4'd3);
    wb(5'd3); cycle("drain_x3", 1'b0, 1'b0, 32'h50, 4'd2);
    wb(5'd4); cycle("drain_x4", 1'b0, 1'b0, 32'h40, 4'd1);
    wb(5'd6); cycle("drain_x6", 1'b0, 1'b0, 32'h00, 4'd0);
    // WAW on x7
    cand(OPC_LOAD, 7'd0, 5'd7, 5'd2, 1'b1, 5'd0, 1'b0);
    cycle("load_x7", 1'b0, 1'b1, 32'h80, 4'd1);
    cand(OPC_LOAD, 7'd0, 5'd7, 5'd2, 1'b1, 5'd0, 1'b0);
    cycle("waw_stall", 1'b1, 1'b0, 32'h80, 4'd1);
    cand(OPC_LOAD, 7'd0, 5'd7, 5'd2, 1'b1, 5'd0, 1'b0);
    wb(5'd7);
    cycle("waw_wb", 1'b0, 1'b1, 32'h80, 4'd1);
    // FLUSH with a stalled candidate and x7 pending
    cand(OPC_OP, 7'd0, 5'd8, 5'd7, 1'b1, 5'd1, 1'b1);
    cycle("pre_flush", 1'b1, 1'b0, 32'h80, 4'd1);
    cand(OPC_IMM, 7'd0, 5'd9, 5'd1, 1'b1, 5'd0, 1'b0);
    cycle("issue_before_flush", 1'b0, 1'b1, 32'h80, 4'd1);
    cand(OPC_OP, 7'd0, 5'd8, 5'd7, 1'b1, 5'd1, 1'b1);
    FLUSH = 1'b1;
    cycle("flush", 1'b0, 1'b0, 32'h80, 4'd1);
    wb(5'd7);
    cycle("flush_wb", 1'b0, 1'b0, 32'h0, 4'd0);
    // MEM_WAIT blocks an otherwise independent issue
    cand(OPC_IMM, 7'd0, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0);
    MEM_WAIT = 1'b1;
    cycle("mem_wait", 1'b1, 1'b0, 32'h0, 4'd0);
    // Reset mid-operation with three pending writes
    cand(OPC_LOAD, 7'd0, 5'd9, 5'd1, 1'b1, 5'd0, 1'b0);
    cycle("load_x9", 1'b0, 1'b1, 32'h200, 4'd1);
    cand(OPC_LOAD, 7'd0, 5'd10, 5'd1, 1'b1, 5'd0, 1'b0);
    cycle("load_x10", 1'b0, 1'b1, 32'h600, 4'd2);
    cand(OPC_OP, 7'd1, 5'd11, 5'd1, 1'b1, 5'd2, 1'b1);
    cycle("mul_x11", 1'b0, 1'b1, 32'hE00, 4'd3);
    cand(OPC_LOAD, 7'd0, 5'd12, 5'd1, 1'b1, 5'd0, 1'b0);
    RST = 1'b1;
    cycle("mid_reset", 1'b0, 1'b0, 32'h0, 4'd0);
    wb(5'd9);
    cycle("stray_wb", 1'b0, 1'b0, 32'h0, 4'd0);
    // WB_RD=0 is ignored
    cand(OPC_LOAD, 7'd0, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0);
    cycle("load_x5", 1'b0, 1'b1, 32'h20, 4'd1);
    wb(5'd0);
    cycle("wb_x0", 1'b0, 1'b0, 32'h20, 4'd1);
    wb(5'd5);
    cycle("wb_x5", 1'b0, 1'b0, 32'h0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/schedule_scoreboard.md
# schedule_scoreboard

Issue controller for the schedule stage. It tracks destination registers of in-flight long-latency instructions (loads, M-extension mul/div) in a 32-entry scoreboard. It holds back any instruction whose rs1/rs2/rd collides with a pending write. It sits between decode stage 2 and the execute units, and drives the stall that freezes decode and the schedule pipeline register.

## Interface
Parameters:
- MAX_PENDING, 4: maximum simultaneously outstanding long-latency writes (1..15).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- FLUSH  in  1  pipeline flush (branch/trap); kills the current candidate and the issued slot.
- MEM_WAIT  in  1  memory not ready; blocks issue, no state change except writeback.
- CHECK_VALID  in  1  decode stage 2 holds a valid candidate instruction.
- CHECK_OPCODE  in  7  candidate opcode.
- CHECK_FUNCT7  in  7  candidate funct7.
- CHECK_RS1, CHECK_RS2, CHECK_RD  in  5 each  candidate register indices.
- CHECK_RS1_USE, CHECK_RS2_USE, CHECK_RD_WE  in  1 each  the corresponding field is architecturally used.
- WB_VALID  in  1  a long-latency unit writes back this cycle.
- WB_RD  in  5  register being written back.
- SCHEDULE_VALID  out  1  registered: an instruction was issued to execute.
- SCHEDULE_STALL  out  1  combinational: candidate not issued this cycle; upstream must hold.
- PENDING_MASK  out  32  registered scoreboard, bit n = xn busy.
- PENDING_CNT  out  4  registered outstanding count.

## Operation
- Long-latency class: opcode LOAD (0000011), or opcode OP (0110011) with funct7 0000001.
- eff_busy = PENDING_MASK & ~(WB_VALID ? onehot(WB_RD) : 0). Writeback resolves a hazard in the same cycle.
- hazard = (RS1_USE & eff_busy[RS1]) | (RS2_USE & eff_busy[RS2]) | (RD_WE & eff_busy[RD]). WAW hazards stall too.
- full = long & (PENDING_CNT == MAX_PENDING) & ~WB_VALID.
- issue = CHECK_VALID & ~hazard & ~full & ~MEM_WAIT & ~FLUSH.
- SCHEDULE_STALL = CHECK_VALID & ~issue & ~FLUSH.
- Mask update: first clear the WB_RD bit, then set the CHECK_RD bit if issue & long & RD_WE & RD≠0. When the same register is both cleared and set, set wins.
- x0 is never marked busy. WB_RD=0 is ignored.
- Count: +1 on a long issue that writes a nonzero rd, −1 on a valid writeback of a nonzero rd. Both together: unchanged. WB_VALID with count 0 is ignored and the count saturates at 0.
- FLUSH clears SCHEDULE_VALID next cycle. It does NOT clear the mask or count, because in-flight units still write back.
- RST: mask 0, count 0, SCHEDULE_VALID 0, which forces SCHEDULE_STALL 0. RST wins over every other input.

## Timing
- Issue latency: 1 cycle, candidate at cycle t gives SCHEDULE_VALID at t+1.
- Scoreboard bit visible on PENDING_MASK at t+1 after issue at t.
- A dependent instruction presented at t+1 stalls until the cycle in which WB_VALID for that register is high, then issues in that same cycle.
- Stall is combinational within the cycle. The stage supports back-to-back issues with no bubble.
- Reset mid-operation: all pending state is dropped. Writebacks for dropped instructions arriving afterwards are ignored, per the saturation rule above.

## Structure
- Shared package/header: opcode constants OP_LOAD and OP_OP, FUNCT7_MULDIV. These are reused by decode and execute.
- Sub-module: `sb_regmask`, a 32-bit set/clear register with x0 masking and set-over-clear priority.
- The count logic and issue logic live in the top module.

## Test plan
- Reset, then an independent ALU op (ADDI x5) with CHECK_VALID=1 -> SCHEDULE_VALID=1 next cycle, STALL never 1, mask 0.
- LOAD x3, then ADD x4,x3,x1 -> mask bit3 set; ADD stalls. WB_VALID, WB_RD=3 at cycle t -> ADD issues at t, and bit3 is 0 at t+1.
- MAX_PENDING=4: issue MUL to x1..x4, then a 5th MUL to x6 -> stall with count=4. A writeback of x2 in the same cycle -> the 5th issues and count stays 4.
- WAW: LOAD x7 pending, then LOAD x7 -> stall until x7 writes back. Issue and writeback in the same cycle -> bit7 remains set.
- FLUSH while a candidate is stalled and one load is pending -> SCHEDULE_VALID=0 next cycle and the mask is retained. The later writeback clears it.
- RST with count=3 -> mask 0 and count 0 next cycle. A subsequent stray WB_VALID leaves count at 0.
